mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Sequences a single-port instruction/data memory bank shared by the IF stage (fetch, read-only) and the
//   MEM stage (load/store) of the 5-stage pipeline. Accepts one request at a time and holds the bank for
//   MEM_LAT cycles. Returns read data with a one-cycle ack pulse and drives per-stage stall lines to the
//   pipeline registers.
// PARAMETERS
//   ADDR_W      8   bank address width (matches the 8-bit PC/ALU slice fed to the banks)
//   DATA_W      32  data word width
//   MEM_LAT     2   bank access cycles, legal range >=1
//   STARVE_MAX  4   consecutive MEM grants tolerated while a fetch waits (used only with the _EN macro)
// PORTS
//   clk        in   1       pipeline clock, rising edge
//   rst        in   1       synchronous, active-high reset
//   if_req     in   1       fetch request, held until if_ack
//   if_addr    in   ADDR_W  fetch address
//   if_rdata   out  DATA_W  fetched instruction, valid while if_ack=1
//   if_ack     out  1       one-cycle completion pulse for fetch
//   if_stall   out  1       if_req & ~if_ack, freezes PC and IF/ID
//   mem_req    in   1       data request, held until mem_ack
//   mem_we     in   1       1=store, 0=load, sampled with mem_req
//   mem_addr   in   ADDR_W  data address
//   mem_wdata  in   DATA_W  store data
//   mem_rdata  out  DATA_W  load data, valid while mem_ack=1
//   mem_ack    out  1       one-cycle completion pulse for data
//   mem_stall  out  1       mem_req & ~mem_ack, freezes all stages up to EX/MEM
//   bank_en    out  1       bank enable, high for exactly MEM_LAT cycles per access
//   bank_we    out  1       bank write enable, qualified by bank_en
//   bank_addr  out  ADDR_W  registered bank address
//   bank_wdata out  DATA_W  registered bank write data
//   bank_rdata in   DATA_W  bank read data, valid in the last cycle that bank_en is high
//   busy       out  1       state != IDLE
// BEHAVIOUR
//   FSM IDLE -> BUSY -> RESP -> IDLE. Reset: IDLE, all acks/bank_en/bank_we/busy=0, rdata/addr/wdata regs=0.
//   Reset also sets cnt=0, winner=IF, starve=0.
//   IDLE: when any req is high at the clock edge, pick a winner and latch its addr, wdata and we.
//     A fetch always has we=0. Load cnt=MEM_LAT-1 and go to BUSY. With no request, stay in IDLE.
//   Arbitration, both reqs high: MEM wins (older instruction). Single req: that port wins.
//   BUSY: bank_en=1 with bank_* stable for all MEM_LAT cycles. cnt decrements.
//     At cnt==0: capture bank_rdata into the winner's rdata reg and go to RESP.
//   RESP: the winner's ack=1 for one cycle, then IDLE. Requests are not sampled in RESP.
//     A requester deasserts req in the cycle after ack.
//   Latency: req first seen in IDLE at cycle 0 -> bank_en in cycles 1..MEM_LAT -> ack in cycle MEM_LAT+1.
//     Back-to-back issue is possible from cycle MEM_LAT+2.
//   The loser's req stays pending. It is serviced at the next IDLE without re-arbitration penalty.
//   Store: bank_we=1 throughout BUSY. mem_rdata in the ack cycle holds the value read (don't-care).
//   rdata regs hold their last value outside ack cycles.
//   Reset mid-access: FSM to IDLE next edge, bank_en/bank_we drop, no ack is issued.
//     A store cut short by reset has an undefined commit status.
//   A req dropped before ack is illegal. The access still completes and acks, and the requester ignores it.
//   stall outputs are combinational from req/ack. No path exists from bank_rdata to the stall outputs.
// CONFIGURATION
//   FETCH_STARVE_GUARD_EN defined:
//     - 3-bit-min counter starve increments on each MEM grant made while if_req=1.
//     - starve clears on an IF grant or when if_req=0.
//     - When starve==STARVE_MAX and both reqs are high in IDLE, IF wins.
//   Undefined: strict MEM priority. The starve counter is not present in the netlist.
// TESTING
//   1 MEM_LAT=2, if_req addr 0x04, bank returns 0x8C220000 -> bank_en cycles 1-2, if_ack cycle 3,
//     if_rdata=0x8C220000, if_stall 1 in cycles 0-2.
//   2 mem_req we=1 addr 0x10 wdata 0xDEADBEEF -> bank_we=1 for 2 cycles at addr 0x10, mem_ack cycle 3,
//     if_ack never pulses.
//   3 if_req and mem_req rise the same cycle -> MEM serviced first (mem_ack cycle 3),
//     IF issued cycle 4, if_ack cycle 7.
//   4 rst pulsed in BUSY cycle 1 -> bank_en=0 next cycle, no ack, busy=0, next req serviced normally.
//   5 Guard on, STARVE_MAX=4, if_req held, mem_req re-asserted after every ack -> 4 MEM grants, then
//     IF granted; with guard off IF never granted while mem_req is continuous.
//   6 MEM_LAT=1 sweep -> bank_en exactly 1 cycle, ack cycle 2, back-to-back requests issue every 3 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory bank sequencer shared by the IF (fetch) and MEM (load/store) pipeline stages.
// Optional feature: define FETCH_STARVE_GUARD_EN to let a waiting fetch win after STARVE_MAX MEM grants.
module mem_port_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   output logic              if_stall,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ack,
   output logic              mem_stall,
   output logic              bank_en,
   output logic              bank_we,
   output logic [ADDR_W-1:0] bank_addr,
   output logic [DATA_W-1:0] bank_wdata,
   input  logic [DATA_W-1:0] bank_rdata,
   output logic              busy
);

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

   state_t              r_state;
   state_t              w_next;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_win_mem;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_if_rdata;
   logic [DATA_W-1:0]   r_mem_rdata;
   logic                w_any_req;
   logic                w_grant_mem;
   logic                w_issue;

   assign w_any_req = if_req | mem_req;
   assign w_issue   = (r_state == S_IDLE) & w_any_req;

`ifdef FETCH_STARVE_GUARD_EN
   localparam int ST_W = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;

   logic [ST_W-1:0] r_starve;
   logic            w_starved;

   assign w_starved   = (r_starve == ST_W'(STARVE_MAX));
   assign w_grant_mem = mem_req & ~(if_req & w_starved);

   // Counts MEM grants that overtook a waiting fetch; any fetch grant or idle fetch port clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve <= '0;
      end else if (!if_req) begin
         r_starve <= '0;
      end else if (w_issue) begin
         r_starve <= w_grant_mem ? r_starve + 1'b1 : '0;
      end
   end
`else
   assign w_grant_mem = mem_req;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_any_req) w_next = S_BUSY;
         S_BUSY:  if (r_cnt == '0) w_next = S_RESP;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      bank_en = 1'b0;
      bank_we = 1'b0;
      busy    = 1'b0;
      if_ack  = 1'b0;
      mem_ack = 1'b0;
      case (r_state)
         S_BUSY: begin
            bank_en = 1'b1;
            bank_we = r_we;
            busy    = 1'b1;
         end
         S_RESP: begin
            busy    = 1'b1;
            if_ack  = ~r_win_mem;
            mem_ack = r_win_mem;
         end
         default: ;
      endcase
   end

   // Request latch at issue, countdown while the bank is held, read capture on the last bank cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_win_mem   <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_if_rdata  <= '0;
         r_mem_rdata <= '0;
      end else if (w_issue) begin
         r_cnt     <= CNT_W'(MEM_LAT - 1);
         r_win_mem <= w_grant_mem;
         r_we      <= w_grant_mem & mem_we;
         r_addr    <= w_grant_mem ? mem_addr : if_addr;
         r_wdata   <= w_grant_mem ? mem_wdata : '0;
      end else if (r_state == S_BUSY) begin
         if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end else if (r_win_mem) begin
            r_mem_rdata <= bank_rdata;
         end else begin
            r_if_rdata <= bank_rdata;
         end
      end
   end

   assign bank_addr  = r_addr;
   assign bank_wdata = r_wdata;
   assign if_rdata   = r_if_rdata;
   assign mem_rdata  = r_mem_rdata;
   assign if_stall   = if_req & ~if_ack;
   assign mem_stall  = mem_req & ~mem_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: an ack scoreboard on a MEM_LAT=2 instance plus a MEM_LAT=1 instance.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;

   logic        if_req = 0, mem_req = 0, mem_we = 0;
   logic [7:0]  if_addr = 0, mem_addr = 0;
   logic [31:0] mem_wdata = 0;
   logic [31:0] if_rdata, mem_rdata, bank_wdata, bank_rdata;
   logic [7:0]  bank_addr;
   logic        if_ack, if_stall, mem_ack, mem_stall, bank_en, bank_we, busy;

   logic        b_if_req = 0, b_mem_req = 0, b_mem_we = 0;
   logic [7:0]  b_if_addr = 0, b_mem_addr = 0;
   logic [31:0] b_mem_wdata = 0;
   logic [31:0] b_if_rdata, b_mem_rdata, b_bank_wdata, b_bank_rdata;
   logic [7:0]  b_bank_addr;
   logic        b_if_ack, b_if_stall, b_mem_ack, b_mem_stall, b_bank_en, b_bank_we, b_busy;

   logic [31:0] tbmem [256];

   typedef struct {
      bit          is_mem;
      bit          chk_data;
      logic [31:0] data;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign bank_rdata   = tbmem[bank_addr];
   assign b_bank_rdata = tbmem[b_bank_addr];

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_stall(mem_stall),
      .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr), .bank_wdata(bank_wdata),
      .bank_rdata(bank_rdata), .busy(busy));

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_lat1 (
      .clk(clk), .rst(rst),
      .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
      .if_stall(b_if_stall),
      .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack), .mem_stall(b_mem_stall),
      .bank_en(b_bank_en), .bank_we(b_bank_we), .bank_addr(b_bank_addr), .bank_wdata(b_bank_wdata),
      .bank_rdata(b_bank_rdata), .busy(b_busy));

   // Scoreboard: every ack on the main instance must match the oldest expected completion.
   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] got;
      if (!rst && (if_ack || mem_ack)) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected_ack: got if_ack=%0b mem_ack=%0b at cycle %0d, want no ack",
                     if_ack, mem_ack, cyc);
         end else begin
            e = sb.pop_front();
            if ((mem_ack !== e.is_mem) || (if_ack !== !e.is_mem)) begin
               bad++;
               $display("FAIL sb_port: got if_ack=%0b mem_ack=%0b, want mem=%0b", if_ack, mem_ack, e.is_mem);
            end
            total++;
            if (cyc !== e.cyc) begin
               bad++;
               $display("FAIL sb_ack_cycle: got %0d want %0d", cyc, e.cyc);
            end
            if (e.chk_data) begin
               total++;
               got = e.is_mem ? mem_rdata : if_rdata;
               if (got !== e.data) begin
                  bad++;
                  $display("FAIL sb_rdata: got %h want %h", got, e.data);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      nxt(); nxt();
      rst = 1'b0;
      nxt();
      total++;
      if ({busy, bank_en, bank_we, if_ack, mem_ack} !== 5'b0) begin
         bad++;
         $display("FAIL reset_ctrl: got %b want 00000", {busy, bank_en, bank_we, if_ack, mem_ack});
      end
      total++;
      if ({if_rdata, mem_rdata, bank_wdata, bank_addr} !== '0) begin
         bad++;
         $display("FAIL reset_regs: got %h %h %h %h want zeros", if_rdata, mem_rdata, bank_wdata, bank_addr);
      end
   endtask

   task automatic test_fetch();
      int c0 = cyc;
      if_req = 1; if_addr = 8'h04;
      sb.push_back('{is_mem: 0, chk_data: 1, data: 32'h8C220000, cyc: c0 + 3});
      for (int k = 0; k < 6; k++) begin
         if (k == 4) if_req = 0;
         #1;
         total++;
         if (bank_en !== (k == 1 || k == 2)) begin
            bad++;
            $display("FAIL fetch_bank_en: cycle %0d got %b want %b", k, bank_en, (k == 1 || k == 2));
         end
         total++;
         if (if_stall !== (k <= 2)) begin
            bad++;
            $display("FAIL fetch_if_stall: cycle %0d got %b want %b", k, if_stall, (k <= 2));
         end
         if (k == 1) begin
            total++;
            if ({bank_addr, bank_we} !== {8'h04, 1'b0}) begin
               bad++;
               $display("FAIL fetch_bank_addr: got %h we=%b want 04 we=0", bank_addr, bank_we);
            end
         end
         nxt();
      end
      total++;
      if (if_rdata !== 32'h8C220000) begin
         bad++;
         $display("FAIL fetch_rdata_hold: got %h want 8c220000", if_rdata);
      end
   endtask

   task automatic test_store();
      int c0 = cyc;
      mem_req = 1; mem_we = 1; mem_addr = 8'h10; mem_wdata = 32'hDEADBEEF;
      sb.push_back('{is_mem: 1, chk_data: 0, data: 32'h0, cyc: c0 + 3});
      for (int k = 0; k < 6; k++) begin
         if (k == 4) begin mem_req = 0; mem_we = 0; end
         #1;
         total++;
         if (bank_we !== (k == 1 || k == 2) || bank_en !== (k == 1 || k == 2)) begin
            bad++;
            $display("FAIL store_bank_we: cycle %0d got en=%b we=%b want %b", k, bank_en, bank_we,
                     (k == 1 || k == 2));
         end
         if (k == 1 || k == 2) begin
            total++;
            if ({bank_addr, bank_wdata} !== {8'h10, 32'hDEADBEEF}) begin
               bad++;
               $display("FAIL store_bank_data: got %h %h want 10 deadbeef", bank_addr, bank_wdata);
            end
         end
         total++;
         if (if_ack !== 1'b0) begin
            bad++;
            $display("FAIL store_if_ack: cycle %0d got %b want 0", k, if_ack);
         end
         nxt();
      end
   endtask

   task automatic test_both_same_cycle();
      int c0 = cyc;
      if_req = 1; if_addr = 8'h20;
      mem_req = 1; mem_we = 0; mem_addr = 8'h30;
      sb.push_back('{is_mem: 1, chk_data: 1, data: tbmem[8'h30], cyc: c0 + 3});
      sb.push_back('{is_mem: 0, chk_data: 1, data: tbmem[8'h20], cyc: c0 + 7});
      for (int k = 0; k < 10; k++) begin
         if (k == 4) mem_req = 0;
         if (k == 8) if_req = 0;
         #1;
         total++;
         if (bank_en !== (k == 1 || k == 2 || k == 5 || k == 6)) begin
            bad++;
            $display("FAIL both_bank_en: cycle %0d got %b", k, bank_en);
         end
         total++;
         if ({if_stall, mem_stall} !== {(k <= 6), (k <= 2)}) begin
            bad++;
            $display("FAIL both_stalls: cycle %0d got %b%b want %b%b", k, if_stall, mem_stall, (k <= 6), (k <= 2));
         end
         if (k == 1 || k == 5) begin
            total++;
            if (bank_addr !== ((k == 1) ? 8'h30 : 8'h20)) begin
               bad++;
               $display("FAIL both_order: cycle %0d got addr %h want %h", k, bank_addr, (k == 1) ? 8'h30 : 8'h20);
            end
         end
         total++;
         if (busy !== ((k >= 1 && k <= 3) || (k >= 5 && k <= 7))) begin
            bad++;
            $display("FAIL both_busy: cycle %0d got %b", k, busy);
         end
         nxt();
      end
   endtask

   task automatic test_reset_mid_access();
      int c0;
      mem_req = 1; mem_we = 1; mem_addr = 8'h40; mem_wdata = 32'h12345678;
      nxt();
      #1;
      total++;
      if (bank_en !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_busy: got bank_en=%b want 1", bank_en);
      end
      rst = 1; mem_req = 0; mem_we = 0;
      nxt();
      total++;
      if ({bank_en, bank_we, busy, mem_ack, if_ack} !== 5'b0) begin
         bad++;
         $display("FAIL rstmid_drop: got %b want 00000", {bank_en, bank_we, busy, mem_ack, if_ack});
      end
      total++;
      if ({if_rdata, mem_rdata} !== 64'h0) begin
         bad++;
         $display("FAIL rstmid_rdata: got %h %h want 0 0", if_rdata, mem_rdata);
      end
      rst = 0;
      nxt();
      c0 = cyc;
      if_req = 1; if_addr = 8'h08;
      sb.push_back('{is_mem: 0, chk_data: 1, data: tbmem[8'h08], cyc: c0 + 3});
      for (int k = 0; k < 6; k++) begin
         if (k == 4) if_req = 0;
         #1;
         total++;
         if (bank_en !== (k == 1 || k == 2)) begin
            bad++;
            $display("FAIL rstmid_next_en: cycle %0d got %b", k, bank_en);
         end
         nxt();
      end
   endtask

   task automatic test_starve();
      int c0 = cyc;
      int n_mem;
      bit guard;
`ifdef FETCH_STARVE_GUARD_EN
      guard = 1;
`else
      guard = 0;
`endif
      n_mem = guard ? 4 : 5;
      if_req = 1; if_addr = 8'h60;
      mem_req = 1; mem_we = 0; mem_addr = 8'h50;
      for (int g = 0; g < n_mem; g++)
         sb.push_back('{is_mem: 1, chk_data: 1, data: tbmem[8'h50], cyc: c0 + 3 + 4 * g});
      if (guard)
         sb.push_back('{is_mem: 0, chk_data: 1, data: tbmem[8'h60], cyc: c0 + 19});
      for (int k = 0; k < 22; k++) begin
         if (k == 20) begin if_req = 0; mem_req = 0; end
         #1;
         if (k == 17) begin
            total++;
            if (bank_addr !== (guard ? 8'h60 : 8'h50)) begin
               bad++;
               $display("FAIL starve_fifth_grant: got addr %h want %h", bank_addr, guard ? 8'h60 : 8'h50);
            end
         end
         nxt();
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
      end
   endtask

   task automatic test_lat1_back_to_back();
      int n_en = 0;
      b_mem_req = 1; b_mem_we = 0; b_mem_addr = 8'h70;
      for (int k = 0; k < 11; k++) begin
         if (k == 9) b_mem_req = 0;
         #1;
         if (b_bank_en) n_en++;
         total++;
         if (b_bank_en !== (k % 3 == 1 && k <= 7)) begin
            bad++;
            $display("FAIL lat1_bank_en: cycle %0d got %b", k, b_bank_en);
         end
         total++;
         if ({b_mem_ack, b_if_ack} !== {(k % 3 == 2 && k <= 8), 1'b0}) begin
            bad++;
            $display("FAIL lat1_ack: cycle %0d got mem=%b if=%b", k, b_mem_ack, b_if_ack);
         end
         if (b_mem_ack) begin
            total++;
            if (b_mem_rdata !== tbmem[8'h70]) begin
               bad++;
               $display("FAIL lat1_rdata: got %h want %h", b_mem_rdata, tbmem[8'h70]);
            end
         end
         nxt();
      end
      total++;
      if (n_en != 3) begin
         bad++;
         $display("FAIL lat1_en_count: got %0d want 3", n_en);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) tbmem[i] = 32'hA5000000 ^ (i * 32'h01030507);
      tbmem[8'h04] = 32'h8C220000;
      test_reset();
      test_fetch();
      test_store();
      test_both_same_cycle();
      test_reset_mid_access();
      test_starve();
      test_lat1_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
